// File: rtl/fwd_ctrl.sv
// fwd_ctrl: operand-forwarding and load-use hazard control for the 5-stage pipeline.
// Keeps shadow copies of the ID/EX, EX/MEM and MEM/WB destination information,
// drives the two ALU-operand forwarding selects and a one-cycle load-use stall.
// Optional feature: define FWD_STALL_CNT_EN to add the saturating stall counter
// (stall_cnt_o); without it the port and its register are absent.
module fwd_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             stall_o
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o
`endif
);

    // Mux select encoding: matches the data-input order of the operand muxes.
    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] SEL_MEMWB = 2'd1;
    localparam logic [1:0] SEL_EXMEM = 2'd2;

    if (REG_W < 1 || CNT_W < 1) begin : g_param_check
        $error("fwd_ctrl: REG_W and CNT_W must be positive");
    end

    // ID/EX shadow record
    logic [REG_W-1:0] idex_rs;
    logic [REG_W-1:0] idex_rt;
    logic [REG_W-1:0] idex_rd;
    logic             idex_regwrite;
    logic             idex_memread;

    // EX/MEM shadow record
    logic [REG_W-1:0] exmem_rd;
    logic             exmem_regwrite;

    // MEM/WB shadow record
    logic [REG_W-1:0] memwb_rd;
    logic             memwb_regwrite;

    logic             bubble;

    // Select for one operand: EX/MEM wins over MEM/WB, register 0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] em_rd,
        input logic             em_rw,
        input logic [REG_W-1:0] mw_rd,
        input logic             mw_rw
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (em_rw && (em_rd != '0) && (em_rd == src)) begin
            sel = SEL_EXMEM;
        end else if (mw_rw && (mw_rd != '0) && (mw_rd == src)) begin
            sel = SEL_MEMWB;
        end
        return sel;
    endfunction

    // Load-use hazard: a load still in ID/EX whose destination is read by ID.
    always_comb begin
        stall_o = 1'b0;
        if (idex_memread && (idex_rd != '0) &&
            ((idex_rd == id_rs_i) || (idex_rd == id_rt_i))) begin
            stall_o = 1'b1;
        end
        bubble = stall_o | flush_i;
    end

    // Forwarding selects for the instruction currently in EX (registers only).
    always_comb begin
        fwd_a_o = fwd_sel(idex_rs, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
        fwd_b_o = fwd_sel(idex_rt, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
    end

    // Advance all stage records together; ID/EX takes a bubble on stall or flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idex_rs        <= '0;
            idex_rt        <= '0;
            idex_rd        <= '0;
            idex_regwrite  <= 1'b0;
            idex_memread   <= 1'b0;
            exmem_rd       <= '0;
            exmem_regwrite <= 1'b0;
            memwb_rd       <= '0;
            memwb_regwrite <= 1'b0;
        end else begin
            memwb_rd       <= exmem_rd;
            memwb_regwrite <= exmem_regwrite;
            exmem_rd       <= idex_rd;
            exmem_regwrite <= idex_regwrite;
            if (bubble) begin
                idex_rs       <= '0;
                idex_rt       <= '0;
                idex_rd       <= '0;
                idex_regwrite <= 1'b0;
                idex_memread  <= 1'b0;
            end else begin
                idex_rs       <= id_rs_i;
                idex_rt       <= id_rt_i;
                idex_rd       <= id_rd_i;
                idex_regwrite <= id_regwrite_i;
                idex_memread  <= id_memread_i;
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;

    // Count stall cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (stall_o && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed self-checking bench for fwd_ctrl.
// Inputs change 1 ns after a rising edge; outputs are checked after they settle,
// well away from the next edge.
module tb_fwd_ctrl;

    localparam int REG_W    = 5;
    localparam int TB_CNT_W = 3;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall;
`ifdef FWD_STALL_CNT_EN
    logic [TB_CNT_W-1:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fwd_ctrl #(
        .REG_W(REG_W),
        .CNT_W(TB_CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_rd_i      (id_rd),
        .id_regwrite_i(id_regwrite),
        .id_memread_i (id_memread),
        .flush_i      (flush),
        .fwd_a_o      (fwd_a),
        .fwd_b_o      (fwd_b),
        .stall_o      (stall)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got running exp finished");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input int rs, input int rt, input int rd, input bit rw, input bit mr);
        id_rs       = REG_W'(rs);
        id_rt       = REG_W'(rt);
        id_rd       = REG_W'(rd);
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        flush = 1'b0;
        drive(0, 0, 0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        flush = 1'b0;
        drive(0, 0, 0, 1'b0, 1'b0);
        #2;
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL reset_fwd_a got %0d exp 0", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL reset_fwd_b got %0d exp 0", fwd_b); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall); end
`ifdef FWD_STALL_CNT_EN
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_back_to_back();
        drain();
        drive(1, 2, 3, 1'b1, 1'b0);       // add $3, $1, $2
        tick();
        drive(3, 4, 6, 1'b1, 1'b0);       // sub $6, $3, $4
        tick();
        checks++; if (fwd_a !== 2'd2) begin errors++; $display("FAIL b2b_fwd_a got %0d exp 2", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL b2b_fwd_b got %0d exp 0", fwd_b); end
    endtask

    task automatic test_distance2();
        drain();
        drive(1, 2, 5, 1'b1, 1'b0);       // producer $5
        tick();
        drive(1, 2, 8, 1'b1, 1'b0);       // unrelated
        tick();
        drive(9, 5, 10, 1'b1, 1'b0);      // consumer rt=5
        tick();
        checks++; if (fwd_b !== 2'd1) begin errors++; $display("FAIL dist2_fwd_b got %0d exp 1", fwd_b); end
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL dist2_fwd_a got %0d exp 0", fwd_a); end

        drain();
        drive(1, 2, 5, 1'b1, 1'b0);       // producer $5 (distance 2)
        tick();
        drive(3, 4, 5, 1'b1, 1'b0);       // producer $5 (distance 1)
        tick();
        drive(5, 5, 11, 1'b1, 1'b0);      // consumer rs=rt=5
        tick();
        checks++; if (fwd_b !== 2'd2) begin errors++; $display("FAIL prio_fwd_b got %0d exp 2", fwd_b); end
        checks++; if (fwd_a !== 2'd2) begin errors++; $display("FAIL prio_fwd_a got %0d exp 2", fwd_a); end
    endtask

    task automatic test_load_use();
        drain();
        drive(1, 2, 7, 1'b1, 1'b1);       // lw $7
        tick();
        drive(7, 0, 10, 1'b1, 1'b0);      // consumer rs=7
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0d exp 1", stall); end
`ifdef FWD_STALL_CNT_EN
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL lu_cnt_before got %0d exp 0", stall_cnt); end
`endif
        tick();                           // bubble enters ID/EX, consumer held in ID
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once got %0d exp 0", stall); end
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL lu_bubble_fwd_a got %0d exp 0", fwd_a); end
`ifdef FWD_STALL_CNT_EN
        checks++; if (stall_cnt !== 3'd1) begin errors++; $display("FAIL lu_cnt_after got %0d exp 1", stall_cnt); end
`endif
        tick();
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL lu_fwd_a got %0d exp 1", fwd_a); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_after got %0d exp 0", stall); end
    endtask

    task automatic test_reg_zero();
        drain();
        drive(1, 2, 0, 1'b1, 1'b0);       // writes $0
        tick();
        drive(0, 0, 6, 1'b1, 1'b0);
        tick();
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL r0_fwd_a got %0d exp 0", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL r0_fwd_b got %0d exp 0", fwd_b); end
        drain();
        drive(1, 2, 0, 1'b1, 1'b1);       // load into $0
        tick();
        drive(0, 0, 6, 1'b1, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %0d exp 0", stall); end
    endtask

    task automatic test_flush();
        drain();
        flush = 1'b1;
        drive(1, 2, 4, 1'b1, 1'b0);       // producer $4, squashed
        tick();
        flush = 1'b0;
        drive(4, 0, 6, 1'b1, 1'b0);
        tick();
        tick();
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL flush_bubble_fwd_a got %0d exp 0", fwd_a); end

        // flush only squashes ID/EX: an older producer still forwards
        drain();
        drive(1, 2, 4, 1'b1, 1'b0);
        tick();
        flush = 1'b1;
        drive(1, 2, 9, 1'b1, 1'b0);
        tick();
        flush = 1'b0;
        drive(4, 0, 6, 1'b1, 1'b0);
        tick();
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL flush_keep_fwd_a got %0d exp 1", fwd_a); end

        // flush together with a load-use stall: one bubble only
        drain();
        drive(1, 2, 7, 1'b1, 1'b1);
        tick();
        flush = 1'b1;
        drive(7, 0, 10, 1'b1, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall got %0d exp 1", stall); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall_once got %0d exp 0", stall); end
        tick();
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL flush_stall_fwd_a got %0d exp 1", fwd_a); end
    endtask

    task automatic test_reset_mid();
        drain();
        drive(1, 2, 3, 1'b1, 1'b0);       // producer $3
        tick();
        drive(3, 0, 7, 1'b1, 1'b1);       // lw $7 reading $3
        tick();
        drive(7, 0, 10, 1'b1, 1'b0);      // consumer of $7
        #1;
        checks++; if (fwd_a !== 2'd2) begin errors++; $display("FAIL mid_pre_fwd_a got %0d exp 2", fwd_a); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got %0d exp 1", stall); end
        rst = 1'b1;
        #1;
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL mid_rst_fwd_a got %0d exp 0", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL mid_rst_fwd_b got %0d exp 0", fwd_b); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got %0d exp 0", stall); end
`ifdef FWD_STALL_CNT_EN
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d exp 0", stall_cnt); end
`endif
        @(negedge clk);
        rst = 1'b0;
        drive(1, 2, 9, 1'b1, 1'b0);       // first edge after reset captures this
        tick();
        drive(9, 0, 6, 1'b1, 1'b0);
        tick();
        checks++; if (fwd_a !== 2'd2) begin errors++; $display("FAIL post_rst_fwd_a got %0d exp 2", fwd_a); end
    endtask

`ifdef FWD_STALL_CNT_EN
    task automatic test_stall_cnt_sat();
        int exp_cnt;
        drain();
        exp_cnt = stall_cnt;              // start value known from prior tests: 0
        checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL sat_start got %0d exp 0", stall_cnt); end
        for (int i = 1; i <= 9; i++) begin
            drive(1, 2, 7, 1'b1, 1'b1);
            tick();
            drive(7, 0, 0, 1'b0, 1'b0);
            tick();
            tick();
            exp_cnt = (i > 7) ? 7 : i;
            checks++;
            if (int'(stall_cnt) !== exp_cnt) begin
                errors++;
                $display("FAIL sat_cnt_%0d got %0d exp %0d", i, stall_cnt, exp_cnt);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_reg_zero();
        test_flush();
        test_reset_mid();
`ifdef FWD_STALL_CNT_EN
        test_stall_cnt_sat();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
